// File: rtl/backend_row_policy_ctrl_if.sv
// Signal bundle for backend_row_policy_ctrl: frontend command, slice command and read-return paths.
// The design uses the slave modport; a frontend/slice model uses the master modport.
interface backend_row_policy_ctrl_if #(
  parameter int BANK_BITS = 3,
  parameter int ROW_BITS  = 14,
  parameter int COL_BITS  = 10,
  parameter int DATA_BITS = 128
);
  logic                 i_frontend_command_valid;
  logic                 o_backend_controller_ready;
  logic                 i_frontend_op;
  logic [BANK_BITS-1:0] i_frontend_bank;
  logic [ROW_BITS-1:0]  i_frontend_row;
  logic [COL_BITS-1:0]  i_frontend_col;
  logic [DATA_BITS-1:0] i_frontend_write_data;
  logic                 o_cmd_valid;
  logic                 i_cmd_ready;
  logic                 o_cmd_r_w;
  logic [BANK_BITS-1:0] o_cmd_bank;
  logic [ROW_BITS-1:0]  o_cmd_row;
  logic [COL_BITS-1:0]  o_cmd_col;
  logic                 o_cmd_auto_precharge;
  logic [DATA_BITS-1:0] o_cmd_write_data;
  logic [DATA_BITS-1:0] i_slice_read_data;
  logic                 i_slice_read_data_valid;
  logic [DATA_BITS-1:0] o_backend_read_data;
  logic                 o_backend_read_data_valid;
  logic                 i_frontend_controller_ready;
  logic                 o_rd_overflow;

  modport slave (
    input  i_frontend_command_valid, i_frontend_op, i_frontend_bank, i_frontend_row,
           i_frontend_col, i_frontend_write_data, i_cmd_ready, i_slice_read_data,
           i_slice_read_data_valid, i_frontend_controller_ready,
    output o_backend_controller_ready, o_cmd_valid, o_cmd_r_w, o_cmd_bank, o_cmd_row,
           o_cmd_col, o_cmd_auto_precharge, o_cmd_write_data, o_backend_read_data,
           o_backend_read_data_valid, o_rd_overflow
  );

  modport master (
    output i_frontend_command_valid, i_frontend_op, i_frontend_bank, i_frontend_row,
           i_frontend_col, i_frontend_write_data, i_cmd_ready, i_slice_read_data,
           i_slice_read_data_valid, i_frontend_controller_ready,
    input  o_backend_controller_ready, o_cmd_valid, o_cmd_r_w, o_cmd_bank, o_cmd_row,
           o_cmd_col, o_cmd_auto_precharge, o_cmd_write_data, o_backend_read_data,
           o_backend_read_data_valid, o_rd_overflow
  );
endinterface

// File: rtl/backend_row_policy_ctrl.sv
// Multi-bank backend command translator with adaptive per-bank auto-precharge prediction and read buffer.
// Optional macro BACKEND_COL_END_AP_EN: an end-of-row column forces auto-precharge on the issued command.
module backend_row_policy_ctrl #(
  parameter int BANK_NUM     = 8,
  parameter int ROW_BITS     = 14,
  parameter int COL_BITS     = 10,
  parameter int DATA_BITS    = 128,
  parameter int CMD_Q_DEPTH  = 4,
  parameter int RD_BUF_DEPTH = 4,
  parameter int AP_THRESH    = 2
) (
  input logic                      clk,
  input logic                      power_on_rst,
  backend_row_policy_ctrl_if.slave bus
);
  localparam int BANK_BITS = $clog2(BANK_NUM);
  localparam int CQ_AW     = $clog2(CMD_Q_DEPTH);
  localparam int RB_AW     = $clog2(RD_BUF_DEPTH);
  localparam logic [CQ_AW:0] CQ_FULL = (CQ_AW+1)'(CMD_Q_DEPTH);
  localparam logic [CQ_AW:0] CQ_ONE  = (CQ_AW+1)'(1);
  localparam logic [RB_AW:0] RB_FULL = (RB_AW+1)'(RD_BUF_DEPTH);
  localparam logic [RB_AW:0] RB_ONE  = (RB_AW+1)'(1);
  localparam logic [2:0]     AP_TH   = 3'(AP_THRESH);

  typedef struct packed {
    logic                 op;
    logic [BANK_BITS-1:0] bank;
    logic [ROW_BITS-1:0]  row;
    logic [COL_BITS-1:0]  col;
    logic [DATA_BITS-1:0] data;
  } cmd_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  cmd_t                 cq_mem [CMD_Q_DEPTH];
  logic [CQ_AW-1:0]     cq_wr, cq_rd, cq_nxt;
  logic [CQ_AW:0]       cq_cnt;
  logic                 cq_empty, cq_push, cq_pop;
  cmd_t                 head, nxt;

  logic [DATA_BITS-1:0] rb_mem [RD_BUF_DEPTH];
  logic [RB_AW-1:0]     rb_wr, rb_rd;
  logic [RB_AW:0]       rb_cnt;
  logic                 rb_empty, rb_full, rb_push, rb_pop, rd_ovf;

  logic [ROW_BITS-1:0]  last_row [BANK_NUM];
  logic [1:0]           ctr [BANK_NUM];
  logic [BANK_NUM-1:0]  row_vld;
  logic                 ap, hit;

  assign cq_empty = (cq_cnt == '0);
  assign cq_nxt   = cq_rd + CQ_AW'(1);
  assign head     = cq_mem[cq_rd];
  assign nxt      = cq_mem[cq_nxt];
  assign cq_push  = bus.i_frontend_command_valid && (cq_cnt != CQ_FULL);
  assign cq_pop   = !cq_empty && bus.i_cmd_ready;

  // Lookahead on the next queued command wins over the history counter; end-of-row may override both.
  always_comb begin
    ap = ({1'b0, ctr[head.bank]} < AP_TH);
    if (cq_cnt >= (CQ_AW+1)'(2)) begin
      if (nxt.bank == head.bank) ap = (nxt.row != head.row);
    end
`ifdef BACKEND_COL_END_AP_EN
    if (&head.col) ap = 1'b1;
`endif
  end

  assign hit = row_vld[head.bank] && (last_row[head.bank] == head.row);

  always_ff @(posedge clk) begin
    if (cq_push) cq_mem[cq_wr] <= '{op: bus.i_frontend_op, bank: bus.i_frontend_bank,
                                    row: bus.i_frontend_row, col: bus.i_frontend_col,
                                    data: bus.i_frontend_write_data};
    if (rb_push) rb_mem[rb_wr] <= bus.i_slice_read_data;
  end

  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      cq_wr  <= '0;
      cq_rd  <= '0;
      cq_cnt <= '0;
    end else begin
      if (cq_push) cq_wr <= cq_wr + CQ_AW'(1);
      if (cq_pop)  cq_rd <= cq_nxt;
      if (cq_push && !cq_pop)      cq_cnt <= cq_cnt + CQ_ONE;
      else if (!cq_push && cq_pop) cq_cnt <= cq_cnt - CQ_ONE;
    end
  end

  // A page closed by auto-precharge clears row_vld so the next access to that bank counts as a miss.
  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      for (int b = 0; b < BANK_NUM; b++) begin
        ctr[b]      <= 2'b01;
        last_row[b] <= '0;
      end
      row_vld <= '0;
    end else if (cq_pop) begin
      ctr[head.bank]      <= hit ? sat_inc(ctr[head.bank]) : sat_dec(ctr[head.bank]);
      last_row[head.bank] <= head.row;
      row_vld[head.bank]  <= !ap;
    end
  end

  assign rb_empty = (rb_cnt == '0);
  assign rb_full  = (rb_cnt == RB_FULL);
  assign rb_pop   = !rb_empty && bus.i_frontend_controller_ready;
  assign rb_push  = bus.i_slice_read_data_valid && (!rb_full || rb_pop);

  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      rb_wr  <= '0;
      rb_rd  <= '0;
      rb_cnt <= '0;
      rd_ovf <= 1'b0;
    end else begin
      if (rb_push) rb_wr <= rb_wr + RB_AW'(1);
      if (rb_pop)  rb_rd <= rb_rd + RB_AW'(1);
      if (rb_push && !rb_pop)      rb_cnt <= rb_cnt + RB_ONE;
      else if (!rb_push && rb_pop) rb_cnt <= rb_cnt - RB_ONE;
      if (bus.i_slice_read_data_valid && !rb_push) rd_ovf <= 1'b1;
    end
  end

  // Data outputs are masked while empty so stale or unreset storage never reaches the ports.
  assign bus.o_backend_controller_ready = (cq_cnt != CQ_FULL);
  assign bus.o_cmd_valid                = !cq_empty;
  assign bus.o_cmd_r_w                  = head.op & !cq_empty;
  assign bus.o_cmd_bank                 = head.bank & {BANK_BITS{!cq_empty}};
  assign bus.o_cmd_row                  = head.row & {ROW_BITS{!cq_empty}};
  assign bus.o_cmd_col                  = head.col & {COL_BITS{!cq_empty}};
  assign bus.o_cmd_auto_precharge       = ap & !cq_empty;
  assign bus.o_cmd_write_data           = head.data & {DATA_BITS{!cq_empty}};
  assign bus.o_backend_read_data        = rb_mem[rb_rd] & {DATA_BITS{!rb_empty}};
  assign bus.o_backend_read_data_valid  = !rb_empty;
  assign bus.o_rd_overflow              = rd_ovf;
endmodule
